hazard_ctrl: RTL and testbench

Register scoreboard and issue controller for the ID→EX boundary of the core pipeline. Tracks one reservation bit per architectural register, decides each cycle whether the instruction held in ID may issue to EX, and generates the ID→IF stall. Reservations are set on issue of a writing instruction and released by EX writeback. Also counts stall cycles and flags protocol errors and pipeline deadlock for debug.

---
 rtl/hazard_ctrl.sv | 88 ++++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Register scoreboard and issue controller at the ID->EX boundary: one reservation
// bit per register, issue/stall decision, stall statistics and sticky debug flags.
module hazard_ctrl #(
    parameter int NREG        = 16,
    parameter int NW          = 4,
    parameter int STALL_LIMIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_v_i,
    input  logic [NW-1:0]   id_rd_name_i,
    input  logic [NW-1:0]   id_rs_name_i,
    input  logic            id_use_rd_i,
    input  logic            id_use_rs_i,
    input  logic            id_wb_i,
    input  logic            ex_ready_i,
    input  logic            flush_i,
    input  logic            wb_i,
    input  logic [NW-1:0]   wb_rd_name_i,
    output logic            issue_o,
    output logic            stall_idif_o,
    output logic [NREG-1:0] reserved_o,
    output logic            busy_o,
    output logic [15:0]     stall_cnt_o,
    output logic            err_o,
    output logic            deadlock_o
);

    logic [NREG-1:0] res;
    logic [15:0]     stall_cnt;
    logic [15:0]     run_cnt;
    logic            err;
    logic            dead;

    logic            hazard;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            bad_release;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Last term blocks a second writer to a register that is still outstanding (WAW).
    always_comb begin
        hazard = id_v_i & ((id_use_rd_i & res[id_rd_name_i]) |
                           (id_use_rs_i & res[id_rs_name_i]) |
                           (id_wb_i     & res[id_rd_name_i]));
        issue_o      = id_v_i & ~hazard & ex_ready_i & ~flush_i;
        stall_idif_o = id_v_i & ~issue_o & ~flush_i;
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_o && id_wb_i) set_mask[id_rd_name_i] = 1'b1;
        if (wb_i)               clr_mask[wb_rd_name_i] = 1'b1;
        bad_release = wb_i & ~res[wb_rd_name_i] & ~set_mask[wb_rd_name_i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res       <= '0;
            stall_cnt <= '0;
            run_cnt   <= '0;
            err       <= 1'b0;
            dead      <= 1'b0;
        end else begin
            // Set is applied after clear so a same-cycle set wins.
            res <= (res & ~clr_mask) | set_mask;
            if (bad_release) err <= 1'b1;
            if (stall_idif_o) begin
                stall_cnt <= sat_inc16(stall_cnt);
                run_cnt   <= sat_inc16(run_cnt);
                if ({1'b0, run_cnt} + 17'd1 >= 17'(STALL_LIMIT)) dead <= 1'b1;
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign reserved_o  = res;
    assign busy_o      = |res;
    assign stall_cnt_o = stall_cnt;
    assign err_o       = err;
    assign deadlock_o  = dead;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance with a short
// stall limit covers deadlock detection.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_v, id_use_rd, id_use_rs, id_wb, ex_ready, flush, wb;
    logic [3:0]  id_rd, id_rs, wb_rd;

    logic        issue, stall, busy, err, dead;
    logic [15:0] reserved, stall_cnt;
    logic        issue4, stall4, busy4, err4, dead4;
    logic [15:0] reserved4, stall_cnt4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_v_i(id_v), .id_rd_name_i(id_rd), .id_rs_name_i(id_rs),
        .id_use_rd_i(id_use_rd), .id_use_rs_i(id_use_rs), .id_wb_i(id_wb),
        .ex_ready_i(ex_ready), .flush_i(flush), .wb_i(wb), .wb_rd_name_i(wb_rd),
        .issue_o(issue), .stall_idif_o(stall), .reserved_o(reserved), .busy_o(busy),
        .stall_cnt_o(stall_cnt), .err_o(err), .deadlock_o(dead)
    );

    hazard_ctrl #(.NREG(16), .NW(4), .STALL_LIMIT(4)) dut4 (
        .clk(clk), .rst(rst), .id_v_i(id_v), .id_rd_name_i(id_rd), .id_rs_name_i(id_rs),
        .id_use_rd_i(id_use_rd), .id_use_rs_i(id_use_rs), .id_wb_i(id_wb),
        .ex_ready_i(ex_ready), .flush_i(flush), .wb_i(wb), .wb_rd_name_i(wb_rd),
        .issue_o(issue4), .stall_idif_o(stall4), .reserved_o(reserved4), .busy_o(busy4),
        .stall_cnt_o(stall_cnt4), .err_o(err4), .deadlock_o(dead4)
    );

    task automatic idle();
        id_v = 0; id_use_rd = 0; id_use_rs = 0; id_wb = 0;
        id_rd = 0; id_rs = 0; ex_ready = 1; flush = 0; wb = 0; wb_rd = 0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic issue_writer(input logic [3:0] r);
        idle();
        id_v = 1; id_wb = 1; id_rd = r;
        #1;
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL issue_writer r%0d: issue=%b want 1", r, issue); end
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (reserved !== 16'h0) begin errors++; $display("FAIL reset_reserved: got %h want 0000", reserved); end
        checks++; if ({busy, err, dead} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/err/dead=%b want 000", {busy, err, dead}); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt: got %h want 0000", stall_cnt); end
        checks++; if ({issue, stall} !== 2'b00) begin errors++; $display("FAIL reset_idle_outputs: issue/stall=%b want 00", {issue, stall}); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        issue_writer(4'd3);
        issue_writer(4'd5);
        wb = 1; wb_rd = 4'd7;
        tick();
        idle();
        checks++; if (reserved !== 16'h0028) begin errors++; $display("FAIL midrun_setup_res: got %h want 0028", reserved); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL midrun_setup_err: got %b want 1", err); end
        #2;
        rst = 1;
        #1;
        checks++; if ({reserved, busy, err, dead, stall_cnt} !== 35'h0) begin
            errors++; $display("FAIL midrun_async_reset: res=%h busy=%b err=%b dead=%b cnt=%h want all 0", reserved, busy, err, dead, stall_cnt);
        end
        tick();
        rst = 0;
    endtask

    task automatic test_raw();
        do_reset();
        issue_writer(4'd3);
        id_v = 1; id_use_rs = 1; id_rs = 4'd3;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin wb = 1; wb_rd = 4'd3; end
            #1;
            checks++; if ({issue, stall} !== 2'b01) begin errors++; $display("FAIL raw_stall_c%0d: issue/stall=%b want 01", c, {issue, stall}); end
            tick();
        end
        wb = 0;
        #1;
        checks++; if ({issue, stall} !== 2'b10) begin errors++; $display("FAIL raw_issue_c5: issue/stall=%b want 10", {issue, stall}); end
        checks++; if (reserved[3] !== 1'b0) begin errors++; $display("FAIL raw_released: res[3]=%b want 0", reserved[3]); end
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL raw_stall_cnt: got %0d want 4", stall_cnt); end
        tick();
        idle();
    endtask

    task automatic test_waw();
        do_reset();
        issue_writer(4'd5);
        id_v = 1; id_wb = 1; id_rd = 4'd5;
        #1;
        checks++; if ({issue, stall} !== 2'b01) begin errors++; $display("FAIL waw_stall: issue/stall=%b want 01", {issue, stall}); end
        tick();
        wb = 1; wb_rd = 4'd5;
        #1;
        checks++; if ({issue, stall} !== 2'b01) begin errors++; $display("FAIL waw_no_bypass: issue/stall=%b want 01", {issue, stall}); end
        tick();
        wb = 0;
        #1;
        checks++; if ({issue, stall, reserved[5]} !== 3'b100) begin errors++; $display("FAIL waw_issue: issue/stall/res5=%b want 100", {issue, stall, reserved[5]}); end
        tick();
        idle();
        checks++; if (reserved !== 16'h0020) begin errors++; $display("FAIL waw_reset_bit: got %h want 0020", reserved); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL waw_err: got %b want 0", err); end
    endtask

    task automatic test_flush();
        do_reset();
        issue_writer(4'd2);
        id_v = 1; id_use_rs = 1; id_rs = 4'd2;
        repeat (3) tick();
        flush = 1;
        #1;
        checks++; if ({issue, stall} !== 2'b00) begin errors++; $display("FAIL flush_outputs: issue/stall=%b want 00", {issue, stall}); end
        tick();
        flush = 0;
        checks++; if (reserved !== 16'h0004) begin errors++; $display("FAIL flush_reserved: got %h want 0004", reserved); end
        checks++; if (stall_cnt4 !== 16'd3) begin errors++; $display("FAIL flush_stall_cnt: got %0d want 3", stall_cnt4); end
        repeat (3) tick();
        checks++; if (dead4 !== 1'b0) begin errors++; $display("FAIL flush_run_cleared: deadlock=%b want 0", dead4); end
        tick();
        checks++; if (dead4 !== 1'b1) begin errors++; $display("FAIL flush_run_restart: deadlock=%b want 1", dead4); end
        idle();
    endtask

    task automatic test_release();
        do_reset();
        id_v = 1; id_wb = 1; id_rd = 4'd6; wb = 1; wb_rd = 4'd6;
        tick();
        idle();
        checks++; if ({reserved, err} !== {16'h0040, 1'b0}) begin errors++; $display("FAIL set_wins: res=%h err=%b want 0040 0", reserved, err); end
        do_reset();
        wb = 1; wb_rd = 4'd7;
        tick();
        wb = 0;
        checks++; if ({reserved, err} !== {16'h0000, 1'b1}) begin errors++; $display("FAIL spurious_release: res=%h err=%b want 0000 1", reserved, err); end
        repeat (3) tick();
        checks++; if ({busy, err} !== 2'b01) begin errors++; $display("FAIL err_sticky: busy/err=%b want 01", {busy, err}); end
    endtask

    task automatic test_deadlock_saturation();
        do_reset();
        id_v = 1; ex_ready = 0;
        #1;
        checks++; if ({issue, stall} !== 2'b01) begin errors++; $display("FAIL notready_stall: issue/stall=%b want 01", {issue, stall}); end
        repeat (3) tick();
        checks++; if (dead4 !== 1'b0) begin errors++; $display("FAIL deadlock_early: got %b want 0", dead4); end
        tick();
        checks++; if (dead4 !== 1'b1) begin errors++; $display("FAIL deadlock_set: got %b want 1", dead4); end
        ex_ready = 1;
        #1;
        checks++; if (issue4 !== 1'b1) begin errors++; $display("FAIL deadlock_resume_issue: got %b want 1", issue4); end
        tick();
        checks++; if ({dead4, dead} !== 2'b10) begin errors++; $display("FAIL deadlock_sticky: dead4/dead255=%b want 10", {dead4, dead}); end
        checks++; if (stall_cnt4 !== 16'd4) begin errors++; $display("FAIL deadlock_stall_cnt: got %0d want 4", stall_cnt4); end
        ex_ready = 0;
        repeat (65530) tick();
        checks++; if (stall_cnt4 !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe: got %h want fffe", stall_cnt4); end
        checks++; if (dead !== 1'b1) begin errors++; $display("FAIL deadlock_255: got %b want 1", dead); end
        tick();
        checks++; if (stall_cnt4 !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff: got %h want ffff", stall_cnt4); end
        tick();
        checks++; if (stall_cnt4 !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", stall_cnt4); end
        idle();
    endtask

    initial begin
        rst = 0;
        idle();
        test_reset();
        test_reset_midrun();
        test_raw();
        test_waw();
        test_flush();
        test_release();
        test_deadlock_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
